// File: rtl/tdm_pkg.sv
// Shared types and constants for the 8:1 TDM multiplexer.
// Slot-counter width follows TDM_MUX_PARITY_EN (extra parity slot).
package tdm_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

`ifdef TDM_MUX_PARITY_EN
    localparam int CNT_W     = 4;
    localparam int LAST_SLOT = 8;
`else
    localparam int CNT_W     = 3;
    localparam int LAST_SLOT = 7;
`endif

    typedef enum logic {IDLE, SEND} tdm_state_t;
    typedef logic [CNT_W-1:0] slot_idx_t;
    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/tdm_mux8x1_if.sv
// Frame-in / slot-out bus of the TDM multiplexer.
// master is the multiplexer side, slave the frame source and slot consumer.
interface tdm_mux8x1_if
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
);

    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_CH*WIDTH-1:0]   d;
    logic                      out_ready;
    logic [WIDTH-1:0]          y;
    logic                      s0;
    logic                      s1;
    logic                      s2;
    logic                      y_valid;
    logic                      frame_start;
`ifdef TDM_MUX_PARITY_EN
    logic                      par_slot;

    modport master (
        input  in_valid, d, out_ready,
        output in_ready, y, s0, s1, s2, y_valid, frame_start, par_slot
    );

    modport slave (
        output in_valid, d, out_ready,
        input  in_ready, y, s0, s1, s2, y_valid, frame_start, par_slot
    );
`else
    modport master (
        input  in_valid, d, out_ready,
        output in_ready, y, s0, s1, s2, y_valid, frame_start
    );

    modport slave (
        output in_valid, d, out_ready,
        input  in_ready, y, s0, s1, s2, y_valid, frame_start
    );
`endif

endinterface

// File: rtl/tdm_slot_sel.sv
// Combinational WIDTH-generic 8:1 channel selector indexed by slot code.
module tdm_slot_sel
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [NUM_CH*WIDTH-1:0] i_frame,
    input  sel_t                    i_idx,
    output logic [WIDTH-1:0]        o_data
);

    always_comb begin
        o_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (i_idx == sel_t'(k)) begin
                o_data = i_frame[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/tdm_mux8x1.sv
// Sequential 8-to-1 TDM multiplexer: one frame in, eight slots out with select code.
// Define TDM_MUX_PARITY_EN to append a ninth XOR-parity slot flagged by par_slot.
module tdm_mux8x1
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic          clk,
    input  logic          rst,
    tdm_mux8x1_if.master  bus
);

    tdm_state_t              r_state;
    slot_idx_t               r_cnt;
    logic [NUM_CH*WIDTH-1:0] r_frame;
    logic [WIDTH-1:0]        r_y;
    sel_t                    r_sel;
    logic                    r_y_valid;
    logic                    r_frame_start;

    logic                    w_last;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_advance;
    slot_idx_t               w_next_cnt;
    logic [NUM_CH*WIDTH-1:0] w_sel_frame;
    sel_t                    w_sel_idx;
    logic [WIDTH-1:0]        w_slot_data;

    assign w_last     = (r_state == SEND) && (r_cnt == slot_idx_t'(LAST_SLOT));
    assign w_in_ready = (r_state == IDLE) || (w_last && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_advance  = r_y_valid && bus.out_ready;
    assign w_next_cnt = w_accept ? '0 : r_cnt + slot_idx_t'(1);

    // On accept the frame register is not yet loaded, so slot 0 comes straight from d.
    assign w_sel_frame = w_accept ? bus.d : r_frame;
    assign w_sel_idx   = w_next_cnt[SEL_W-1:0];

    tdm_slot_sel #(.WIDTH(WIDTH)) u_slot_sel (
        .i_frame (w_sel_frame),
        .i_idx   (w_sel_idx),
        .o_data  (w_slot_data)
    );

`ifdef TDM_MUX_PARITY_EN
    logic             r_par_slot;
    logic [WIDTH-1:0] w_parity;
    logic             w_par_next;

    always_comb begin
        w_parity = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_parity = w_parity ^ r_frame[k*WIDTH +: WIDTH];
        end
    end

    assign w_par_next   = (w_next_cnt == slot_idx_t'(NUM_CH));
    assign bus.par_slot = r_par_slot;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_frame       <= '0;
            r_y           <= '0;
            r_sel         <= '0;
            r_y_valid     <= 1'b0;
            r_frame_start <= 1'b0;
`ifdef TDM_MUX_PARITY_EN
            r_par_slot    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_state       <= SEND;
            r_cnt         <= '0;
            r_frame       <= bus.d;
            r_y           <= w_slot_data;
            r_sel         <= '0;
            r_y_valid     <= 1'b1;
            r_frame_start <= 1'b1;
`ifdef TDM_MUX_PARITY_EN
            r_par_slot    <= 1'b0;
`endif
        end else if (w_advance) begin
            if (w_last) begin
                // cnt is left at the last slot; only a new accept rewinds it.
                r_state       <= IDLE;
                r_y           <= '0;
                r_sel         <= '0;
                r_y_valid     <= 1'b0;
                r_frame_start <= 1'b0;
`ifdef TDM_MUX_PARITY_EN
                r_par_slot    <= 1'b0;
`endif
            end else begin
                r_cnt         <= w_next_cnt;
                r_frame_start <= 1'b0;
`ifdef TDM_MUX_PARITY_EN
                if (w_par_next) begin
                    r_y        <= w_parity;
                    r_sel      <= '0;
                    r_par_slot <= 1'b1;
                end else begin
                    r_y        <= w_slot_data;
                    r_sel      <= w_sel_idx;
                    r_par_slot <= 1'b0;
                end
`else
                r_y   <= w_slot_data;
                r_sel <= w_sel_idx;
`endif
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.y           = r_y;
    assign bus.s0          = r_sel[0];
    assign bus.s1          = r_sel[1];
    assign bus.s2          = r_sel[2];
    assign bus.y_valid     = r_y_valid;
    assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_tdm_mux8x1.sv
// Directed bench for tdm_mux8x1: reset, single frame, stall, back-to-back, loopback, mid-frame reset.
module tb_tdm_mux8x1;
    import tdm_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    tdm_mux8x1_if #(.WIDTH(1)) bus ();

    tdm_mux8x1 #(.WIDTH(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] sel_now();
        return {bus.s2, bus.s1, bus.s0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_slot(input string tag, input logic [7:0] f, input int k);
        check($sformatf("%s_y%0d", tag, k), 32'(bus.y), 32'(f[k]));
        check($sformatf("%s_sel%0d", tag, k), 32'(sel_now()), 32'(k));
        check($sformatf("%s_vld%0d", tag, k), 32'(bus.y_valid), 32'd1);
        check($sformatf("%s_fs%0d", tag, k), 32'(bus.frame_start), (k == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic accept(input logic [7:0] f);
        bus.d        = f;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.d        = ~f;
    endtask

    initial begin
        logic [7:0] f;
        logic [7:0] fb;
        logic [7:0] rec;
        int         got;
        int         cyc;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.d         = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();

        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_y_valid", 32'(bus.y_valid), 32'd0);
        check("rst_frame_start", 32'(bus.frame_start), 32'd0);
        check("rst_y", 32'(bus.y), 32'd0);
        check("rst_sel", 32'(sel_now()), 32'd0);

        rst = 1'b0;
        tick();

        // Single frame: expected slot data 0,1,0,0,1,1,0,1
        f             = 8'b1011_0010;
        bus.out_ready = 1'b1;
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        accept(f);
        for (int k = 0; k < 8; k++) begin
            check_slot("f1", f, k);
            if (k == 0) check("f1_busy_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        check("f1_end_vld", 32'(bus.y_valid), 32'd0);
        check("f1_end_in_ready", 32'(bus.in_ready), 32'd1);
        check("f1_end_fs", 32'(bus.frame_start), 32'd0);

        // Stall three cycles during slot 4
        f = 8'hA5;
        accept(f);
        for (int k = 0; k < 4; k++) begin
            check_slot("st", f, k);
            tick();
        end
        check_slot("st", f, 4);
        bus.out_ready = 1'b0;
        check("st_hold_in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_slot("st_hold", f, 4);
        end
        bus.out_ready = 1'b1;
        tick();
        for (int k = 5; k < 8; k++) begin
            check_slot("st", f, k);
            tick();
        end
        check("st_end_vld", 32'(bus.y_valid), 32'd0);

        // Back-to-back: second frame offered while slot 7 is consumed
        f  = 8'h3C;
        fb = 8'hC3;
        accept(f);
        for (int k = 0; k < 8; k++) begin
            check_slot("b2b_a", f, k);
            if (k == 6) check("b2b_not_ready6", 32'(bus.in_ready), 32'd0);
            if (k == 7) begin
                bus.d        = fb;
                bus.in_valid = 1'b1;
                check("b2b_ready7", 32'(bus.in_ready), 32'd1);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.d        = 8'h00;
        for (int k = 0; k < 8; k++) begin
            check_slot("b2b_b", fb, k);
            tick();
        end
        check("b2b_end_vld", 32'(bus.y_valid), 32'd0);

        // Loopback through a y_valid-gated 1x8 demultiplexer with random stalls
        for (int fr = 0; fr < 20; fr++) begin
            f             = 8'($urandom);
            bus.out_ready = 1'b1;
            accept(f);
            rec = '0;
            got = 0;
            cyc = 0;
            while (got < 8 && cyc < 200) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                if (bus.y_valid && bus.out_ready) begin
                    rec[sel_now()] = bus.y;
                    got++;
                end
                tick();
                cyc++;
            end
            check($sformatf("loop_frame%0d", fr), 32'(rec), 32'(f));
            check($sformatf("loop_slots%0d", fr), 32'(got), 32'd8);
            check($sformatf("loop_idle%0d", fr), 32'(bus.y_valid), 32'd0);
        end
        bus.out_ready = 1'b1;

        // Reset pulsed asynchronously in slot 3
        f = 8'hFF;
        accept(f);
        tick();
        tick();
        tick();
        check("mid_sel3", 32'(sel_now()), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_vld", 32'(bus.y_valid), 32'd0);
        check("mid_rst_y", 32'(bus.y), 32'd0);
        check("mid_rst_sel", 32'(sel_now()), 32'd0);
        check("mid_rst_fs", 32'(bus.frame_start), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        #1 rst = 1'b0;
        tick();
        check("post_rst_vld", 32'(bus.y_valid), 32'd0);
        f = 8'h81;
        accept(f);
        for (int k = 0; k < 8; k++) begin
            check_slot("post", f, k);
            tick();
        end
        check("post_end_vld", 32'(bus.y_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
